// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner.
// Optional build macro used by this block: SEG7_SCAN_DIM_EN (PWM brightness).
package seg7_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  // Active-low "everything dark" levels for the segment bus and digit selects.
  localparam logic [7:0]            SEG_OFF_N = 8'hFF;
  localparam logic [NUM_DIGITS-1:0] AN_OFF_N  = 6'b111111;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_t;

  typedef logic [IDX_W-1:0] digit_idx_t;

  // Next digit in scan order, wrapping from the leftmost back to digit 0.
  function automatic digit_idx_t next_idx(input digit_idx_t i);
    return (i == digit_idx_t'(NUM_DIGITS - 1)) ? '0 : i + digit_idx_t'(1);
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Bundle of scan-enable, digit patterns and display-side outputs.
// With SEG7_SCAN_DIM_EN defined the bundle also carries the brightness level.
interface seg7_scan_if;
  import seg7_pkg::*;

  logic                  enable;
  logic [7:0]            digit_0;
  logic [7:0]            digit_1;
  logic [7:0]            digit_2;
  logic [7:0]            digit_3;
  logic [7:0]            digit_4;
  logic [7:0]            digit_5;
`ifdef SEG7_SCAN_DIM_EN
  logic [3:0]            bright;
`endif
  logic [7:0]            seg_n;
  logic [NUM_DIGITS-1:0] an_n;
  logic                  frame_tick;

`ifdef SEG7_SCAN_DIM_EN
  modport master (
    output enable, digit_0, digit_1, digit_2, digit_3, digit_4, digit_5, bright,
    input  seg_n, an_n, frame_tick
  );
  modport slave (
    input  enable, digit_0, digit_1, digit_2, digit_3, digit_4, digit_5, bright,
    output seg_n, an_n, frame_tick
  );
`else
  modport master (
    output enable, digit_0, digit_1, digit_2, digit_3, digit_4, digit_5,
    input  seg_n, an_n, frame_tick
  );
  modport slave (
    input  enable, digit_0, digit_1, digit_2, digit_3, digit_4, digit_5,
    output seg_n, an_n, frame_tick
  );
`endif

endinterface

// File: rtl/seg7_scan_timer.sv
// Slot/phase sequencer: slot counter, digit index and BLANK/DRIVE phase.
// All outputs describe the state being entered on the coming clock edge, so
// the top can register its outputs on that same edge.
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  output scan_state_t o_state_nxt,
  output digit_idx_t  o_idx_nxt,
  output logic        o_slot_start,
  output logic        o_frame_start
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  scan_state_t      r_state;
  logic [CNT_W-1:0] r_slot_cnt;
  digit_idx_t       r_idx;

  scan_state_t      w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  digit_idx_t       w_idx_nxt;

  // Next-state decode: enable drop wins from any state, otherwise walk slots.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_slot_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;

    if (!i_enable) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
        BLANK: begin
          if (r_slot_cnt == BLANK_LAST) w_state_nxt = DRIVE;
        end
        DRIVE: begin
          if (r_slot_cnt == SLOT_LAST) begin
            w_state_nxt = BLANK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = next_idx(r_idx);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) begin
      r_state    <= IDLE;
      r_slot_cnt <= '0;
      r_idx      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot_cnt <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
    end
  end

  // A slot starts on every entry into BLANK; a frame starts when that slot is digit 0.
  assign o_state_nxt   = w_state_nxt;
  assign o_idx_nxt     = w_idx_nxt;
  assign o_slot_start  = (w_state_nxt == BLANK) && (r_state != BLANK);
  assign o_frame_start = o_slot_start && (w_idx_nxt == '0);

endmodule

// File: rtl/seg7_scan.sv
// Six-digit common-anode 7-segment scanner with inter-digit blanking,
// frame-coherent pattern capture and a frame tick.
// Optional macro SEG7_SCAN_DIM_EN adds 16-step PWM brightness on the anodes.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int CLK_DIV      = 50000,  // must exceed BLANK_CYCLES
  parameter int BLANK_CYCLES = 16      // must be at least 1
) (
  input  logic        m_clock,
  input  logic        p_reset,
  seg7_scan_if.slave  bus
);

  scan_state_t           w_state_nxt;
  digit_idx_t            w_idx_nxt;
  logic                  w_slot_start;
  logic                  w_frame_start;
  logic                  w_an_gate;
  logic [7:0]            w_digit  [NUM_DIGITS];
  logic [7:0]            r_shadow [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic [7:0]            w_seg_nxt;
  logic [NUM_DIGITS-1:0] r_an_n;
  logic [7:0]            r_seg_n;
  logic                  r_frame_tick;

  seg7_scan_timer #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk           (m_clock),
    .rst_n         (p_reset),
    .i_enable      (bus.enable),
    .o_state_nxt   (w_state_nxt),
    .o_idx_nxt     (w_idx_nxt),
    .o_slot_start  (w_slot_start),
    .o_frame_start (w_frame_start)
  );

  assign w_digit[0] = bus.digit_0;
  assign w_digit[1] = bus.digit_1;
  assign w_digit[2] = bus.digit_2;
  assign w_digit[3] = bus.digit_3;
  assign w_digit[4] = bus.digit_4;
  assign w_digit[5] = bus.digit_5;

  // Capture all six patterns together at frame start so a frame never mixes old and new data.
  always_ff @(posedge m_clock or negedge p_reset) begin
    // NOTE: this small shadow bank is reset because its cleared value is
    // observable; a real RAM array would be left without reset.
    if (!p_reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= '0;
    end else if (w_frame_start) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= w_digit[i];
    end
  end

`ifdef SEG7_SCAN_DIM_EN
  logic [3:0] r_bright_sh;
  logic [3:0] r_pwm_cnt;
  logic [3:0] w_pwm_nxt;

  // The PWM window restarts at each slot start; brightness is frame-coherent like the patterns.
  assign w_pwm_nxt = w_slot_start ? 4'd0 : r_pwm_cnt + 4'd1;
  assign w_an_gate = (w_pwm_nxt <= r_bright_sh);

  // PWM counter and brightness shadow.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      r_pwm_cnt   <= '0;
      r_bright_sh <= '0;
    end else begin
      r_pwm_cnt <= w_pwm_nxt;
      if (w_frame_start) r_bright_sh <= bus.bright;
    end
  end
`else
  // Without dimming there is no PWM window to restart at slot start.
  logic w_unused_slot_start;
  assign w_unused_slot_start = w_slot_start;
  assign w_an_gate           = 1'b1;
`endif

  // Output decode for the state being entered: only DRIVE lights anything.
  always_comb begin
    w_an_nxt  = AN_OFF_N;
    w_seg_nxt = SEG_OFF_N;
    if (w_state_nxt == DRIVE) begin
      w_seg_nxt = ~r_shadow[w_idx_nxt];
      if (w_an_gate) w_an_nxt[w_idx_nxt] = 1'b0;
    end
  end

  // Registered outputs, so the pins change only on the edge that enters a state.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      r_an_n       <= AN_OFF_N;
      r_seg_n      <= SEG_OFF_N;
      r_frame_tick <= 1'b0;
    end else begin
      r_an_n       <= w_an_nxt;
      r_seg_n      <= w_seg_nxt;
      r_frame_tick <= w_frame_start;
    end
  end

  assign bus.an_n       = r_an_n;
  assign bus.seg_n      = r_seg_n;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: reset, scan order, frame coherency, enable
// drop, asynchronous reset and, with SEG7_SCAN_DIM_EN, PWM dimming.
module tb_seg7_scan;

`ifdef SEG7_SCAN_DIM_EN
  localparam int LP_CLK   = 40;
  localparam int LP_BLANK = 4;
`else
  localparam int LP_CLK   = 8;
  localparam int LP_BLANK = 2;
`endif

  logic m_clock = 1'b0;
  logic p_reset = 1'b0;

  seg7_scan_if bus ();

  seg7_scan #(
    .CLK_DIV      (LP_CLK),
    .BLANK_CYCLES (LP_BLANK)
  ) dut (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .bus     (bus)
  );

  always #5 m_clock = ~m_clock;

  int total = 0;
  int bad   = 0;
  int exp_bright = 15;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks cycles c_lo..c_hi of the slot for digit d. Called at a falling edge
  // that precedes the rising edge entering cycle c_lo.
  task automatic expect_slot(input int d, input logic [7:0] pat, input int c_lo, input int c_hi);
    logic [5:0] an_exp;
    logic [7:0] seg_exp;
    for (int c = c_lo; c <= c_hi; c++) begin
      @(negedge m_clock);
      if (c < LP_BLANK) begin
        an_exp  = 6'h3F;
        seg_exp = 8'hFF;
      end else begin
        seg_exp = ~pat;
        an_exp  = ((c % 16) <= exp_bright) ? ~(6'b000001 << d) : 6'h3F;
      end
      check($sformatf("slot%0d cyc%0d an_n", d, c), 32'(bus.an_n), 32'(an_exp));
      check($sformatf("slot%0d cyc%0d seg_n", d, c), 32'(bus.seg_n), 32'(seg_exp));
      if (c == 0)
        check($sformatf("slot%0d frame_tick", d), 32'(bus.frame_tick), (d == 0) ? 32'd1 : 32'd0);
    end
  endtask

  // Continuous ghosting and frame-period monitor.
  int         ghost_err = 0;
  int         samples   = 0;
  int         cyc       = 0;
  int         last_tick = -1;
  int         tick_gap  = 0;
  logic [5:0] prev_an   = 6'h3F;
  logic [7:0] prev_seg  = 8'hFF;

  always @(negedge m_clock) begin
    cyc++;
    samples++;
    if ($countones(~bus.an_n) > 1) ghost_err++;
`ifndef SEG7_SCAN_DIM_EN
    if (bus.an_n !== prev_an && prev_seg !== 8'hFF && bus.seg_n !== 8'hFF) ghost_err++;
`endif
    if (bus.frame_tick === 1'b1) begin
      if (last_tick >= 0) tick_gap = cyc - last_tick;
      last_tick = cyc;
    end
    prev_an  = bus.an_n;
    prev_seg = bus.seg_n;
  end

  logic [7:0] pat [6];

  initial begin
    pat[0] = 8'h3F; pat[1] = 8'h06; pat[2] = 8'h5B;
    pat[3] = 8'h4F; pat[4] = 8'h66; pat[5] = 8'h6D;
    bus.enable  = 1'b1;
    bus.digit_0 = pat[0]; bus.digit_1 = pat[1]; bus.digit_2 = pat[2];
    bus.digit_3 = pat[3]; bus.digit_4 = pat[4]; bus.digit_5 = pat[5];
`ifdef SEG7_SCAN_DIM_EN
    bus.bright = 4'd15;
`endif

    // Reset state.
    repeat (2) @(negedge m_clock);
    check("reset an_n", 32'(bus.an_n), 32'h3F);
    check("reset seg_n", 32'(bus.seg_n), 32'hFF);
    check("reset frame_tick", 32'(bus.frame_tick), 32'd0);

    // Release reset: first frame, digits in order.
    p_reset = 1'b1;
    for (int d = 0; d < 6; d++) expect_slot(d, pat[d], 0, LP_CLK - 1);

    // Second frame: digit_3 changes during digit_1's slot, old value still shown.
    expect_slot(0, pat[0], 0, LP_CLK - 1);
    check("frame period", tick_gap, 6 * LP_CLK);
    expect_slot(1, pat[1], 0, 3);
    bus.digit_3 = 8'h7F;
    expect_slot(1, pat[1], 4, LP_CLK - 1);
    for (int d = 2; d < 6; d++) expect_slot(d, pat[d], 0, LP_CLK - 1);

    // Third frame shows the new digit_3.
    pat[3] = 8'h7F;
    for (int d = 0; d < 6; d++) expect_slot(d, pat[d], 0, LP_CLK - 1);

    // Enable drop in the middle of digit 2's DRIVE phase.
    expect_slot(0, pat[0], 0, LP_CLK - 1);
    expect_slot(1, pat[1], 0, LP_CLK - 1);
    expect_slot(2, pat[2], 0, LP_BLANK + 2);
    bus.enable  = 1'b0;
    bus.digit_0 = 8'h77;
    pat[0]      = 8'h77;
    @(negedge m_clock);
    check("disable an_n", 32'(bus.an_n), 32'h3F);
    check("disable seg_n", 32'(bus.seg_n), 32'hFF);
    check("disable frame_tick", 32'(bus.frame_tick), 32'd0);
    @(negedge m_clock);
    check("idle an_n", 32'(bus.an_n), 32'h3F);
    bus.enable = 1'b1;
    expect_slot(0, pat[0], 0, LP_CLK - 1);
    expect_slot(1, pat[1], 0, LP_CLK - 1);

    // Asynchronous reset between clock edges during DRIVE.
    expect_slot(2, pat[2], 0, LP_BLANK + 1);
    #2 p_reset = 1'b0;
    #1;
    check("async an_n", 32'(bus.an_n), 32'h3F);
    check("async seg_n", 32'(bus.seg_n), 32'hFF);
    check("async frame_tick", 32'(bus.frame_tick), 32'd0);
    @(negedge m_clock);
`ifdef SEG7_SCAN_DIM_EN
    bus.bright = 4'd3;
    exp_bright = 3;
`endif
    p_reset = 1'b1;
    expect_slot(0, pat[0], 0, LP_CLK - 1);

`ifdef SEG7_SCAN_DIM_EN
    begin
      int lows_win;
      int lows_slot;
      lows_win  = 0;
      lows_slot = 0;
      for (int c = 0; c < LP_CLK; c++) begin
        @(negedge m_clock);
        if (bus.an_n[1] == 1'b0) begin
          lows_slot++;
          if (c >= 16 && c < 32) lows_win++;
        end
      end
      check("dim window lows", lows_win, 4);
      check("dim slot lows", lows_slot, 8);
    end
    expect_slot(2, pat[2], 0, 9);
    bus.bright = 4'd15;
    expect_slot(2, pat[2], 10, LP_CLK - 1);
    for (int d = 3; d < 6; d++) expect_slot(d, pat[d], 0, LP_CLK - 1);
    exp_bright = 15;
    expect_slot(0, pat[0], 0, LP_CLK - 1);
`endif
    expect_slot(1, pat[1], 0, LP_CLK - 1);

    check("ghost violations", ghost_err, 0);
    check("monitor active", (samples > 0) ? 32'd1 : 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Downstream of the seg7 digit decoder.
- Takes six decoded 8-bit segment patterns (bit0=a … bit6=g, bit7=dp, 1 = lit) and time-multiplexes them onto one shared active-low segment bus with six active-low digit selects, for common-anode multiplexed 7-segment boards.
- Provides an inter-digit blanking interval against ghosting, frame-coherent capture and a frame tick.

Parameters:
- CLK_DIV, 50000: m_clock cycles per digit slot; must be > BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at the start of each slot with all digits off; must be >= 1.

Ports:
- m_clock  in  1  system clock.
- p_reset  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable; 0 = display dark.
- digit_0..digit_5  in  8 each  decoded segment patterns; digit_0 is the rightmost digit.
- bright  in  4  brightness level (only with SEG7_SCAN_DIM_EN).
- seg_n  out  8  shared segment bus, active-low (~pattern).
- an_n  out  6  digit selects, active-low; bit i selects digit_i.
- frame_tick  out  1  one-cycle pulse at each frame start.

Behaviour:
- Clock and reset: one clock, m_clock. p_reset is asynchronous and active-low. While p_reset=0: an_n=6'b111111, seg_n=8'hFF, frame_tick=0, state=IDLE, slot counter=0, digit index=0, shadow patterns=0.
- States:
  - IDLE: outputs off.
  - BLANK: an_n=111111, seg_n=FF.
  - DRIVE: an_n has only bit idx low; seg_n = ~shadow[idx].
- Transitions:
  - IDLE->BLANK on enable=1, idx=0.
  - BLANK->DRIVE when slot_cnt = BLANK_CYCLES-1.
  - DRIVE->BLANK when slot_cnt = CLK_DIV-1. On this transition idx increments, wrapping 5->0, and slot_cnt returns to 0.
- Slot counter:
  - slot_cnt counts 0..CLK_DIV-1, width $clog2(CLK_DIV).
  - Resets to 0 on every slot start.
- Frame start and capture:
  - Frame start is the first cycle of the idx=0 BLANK slot, including the first slot after IDLE.
  - On that cycle, all six inputs are registered into shadow[0..5] and frame_tick=1.
  - Input changes mid-frame are invisible until the next frame start.
- Output timing: seg_n and an_n are registered outputs, updated on the clock edge that enters each state.
- Slot timing: a slot is exactly CLK_DIV cycles: BLANK_CYCLES blank, then CLK_DIV-BLANK_CYCLES driven. A frame is 6*CLK_DIV cycles.
- enable=0 in any state: on the next edge go to IDLE, with outputs off and idx/slot_cnt cleared. Re-enable always restarts at digit 0 with a blank and a frame tick.
- Async reset mid-DRIVE: outputs go off immediately, without waiting for a clock edge.
- Ghosting guarantee: two different an_n bits are never low in the same cycle, and an_n changes only while seg_n=FF.

Optional Feature:
- Macro: SEG7_SCAN_DIM_EN.
- With the macro defined:
  - bright port exists and is sampled into a shadow register at frame start.
  - A 4-bit pwm_cnt clears at each slot start and free-runs.
  - In DRIVE, an_n[idx] is low only when pwm_cnt <= bright_shadow, i.e. duty (bright+1)/16 of each 16-cycle window. seg_n is unaffected.
  - When the selected anode is gated off, an_n=111111.
- Without the macro: bright port absent, pwm logic absent, full duty in DRIVE.

Decomposition:
- Shared package seg7_pkg:
  - NUM_DIGITS=6.
  - SEG_OFF_N=8'hFF, AN_OFF_N=6'b111111.
  - scan state enum {IDLE, BLANK, DRIVE}.
- One sub-module: seg7_scan_timer. It holds slot_cnt, idx, the BLANK/DRIVE phase, and emits slot_start/frame_start strobes.
- The top holds the shadow registers, the output registers and the optional PWM.

Test Plan (CLK_DIV=8, BLANK_CYCLES=2 unless stated):
- Reset and first slot:
  - Stimulus: p_reset=0 -> an_n=111111, seg_n=FF, frame_tick=0. Release p_reset with enable=1, digit_0=8'h3F.
  - Response: frame_tick=1 for one cycle; 2 blank cycles; then an_n=111110, seg_n=8'hC0 for 6 cycles.
- Scan order:
  - Stimulus: digits 0..5 = 3F,06,5B,4F,66,6D.
  - Response: driven seg_n sequence C0,F9,A4,B0,99,92 with an_n walking bit 0..5. frame_tick pulses every 48 cycles. There is no cycle with two an_n bits low, and no an_n change while seg_n!=FF.
- Frame coherency:
  - Stimulus: change digit_3 from 4F to 7F during the digit_1 slot.
  - Response: seg_n=B0 shown in the current frame; 80 shown in the next frame.
- Enable drop:
  - Stimulus: enable=0 mid-DRIVE of digit 2.
  - Response: next cycle all outputs off. On re-enable, frame_tick fires and digit 0 is shown after 2 blank cycles.
- Async reset:
  - Stimulus: assert p_reset between clock edges during DRIVE.
  - Response: an_n=111111 and seg_n=FF immediately, with no clock edge.
- Dimming (SEG7_SCAN_DIM_EN, CLK_DIV=40, BLANK_CYCLES=4, bright=3):
  - Response: in each 16-cycle PWM window, the anode is low for exactly 4 cycles.
  - Stimulus: bright changed mid-frame.
  - Response: the new value applies only from the next frame.
